// File: rtl/sel_onehot_seq_pkg.sv
// Shared types and helpers for the one-hot select sequencer.
//   state_e : scan FSM states (idle / timed auto-scan)
//   DirUp/DirDn : encoding of the dir input
//   onehot() : index -> one-hot vector, MaxNout wide; callers size-cast to their width
package sel_onehot_seq_pkg;

   localparam int unsigned MaxSelW = 8;
   localparam int unsigned MaxNout = 1 << MaxSelW;

   localparam logic DirUp = 1'b0;
   localparam logic DirDn = 1'b1;

   typedef enum logic {
      StIdle,
      StScan
   } state_e;

   function automatic logic [MaxNout-1:0] onehot(input logic [MaxSelW-1:0] idx);
      return MaxNout'(1) << idx;
   endfunction

endpackage

// File: rtl/sel_onehot_seq_if.sv
// Control/status bundle for sel_onehot_seq.
//   master: controller side, drives en/load/sel/step/dir/auto/dwell, reads y/idx/wrap/busy
//   slave : sequencer side
interface sel_onehot_seq_if #(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DWELL_W = 8
);
   localparam int unsigned NOUT = 1 << SEL_W;

   logic               en;
   logic               load;
   logic [SEL_W-1:0]   sel;
   logic               step;
   logic               dir;
   logic               auto;
   logic [DWELL_W-1:0] dwell;
   logic [NOUT-1:0]    y;
   logic [SEL_W-1:0]   idx;
   logic               wrap;
   logic               busy;

   modport master (
      output en, load, sel, step, dir, auto, dwell,
      input  y, idx, wrap, busy
   );

   modport slave (
      input  en, load, sel, step, dir, auto, dwell,
      output y, idx, wrap, busy
   );
endinterface

// File: rtl/sel_onehot_seq_dwell_timer.sv
// Dwell counter for timed auto-scan.
//   clk, rst : clock, async active-high reset
//   run_i    : count enable (scan active); low holds the count at zero
//   clr_i    : restart the dwell period (a load/step happened this cycle)
//   dwell_i  : period minus one, sampled live
//   tick_o   : advance request, high when the count has reached dwell_i
module sel_onehot_seq_dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_i,
   input  logic               clr_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic               tick_o
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   // >= rather than == so a live drop of dwell below the count fires at once.
   assign tick_o = run_i && (cnt_q >= dwell_i);

   always_comb begin
      cnt_d = cnt_q + DWELL_W'(1);
      if (clr_i || !run_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sel_onehot_seq.sv
// Registered index-to-one-hot selector with enable, manual step and timed auto-scan.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sel_onehot_seq_if
//     en gates y to zero, load/sel set the index, step/dir move it by one,
//     auto/dwell advance it every dwell+1 cycles; y/idx/wrap/busy are registered status.
// Priority per edge: load > step > auto tick, one index update at most.
module sel_onehot_seq
   import sel_onehot_seq_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DWELL_W = 8,
   parameter bit          WRAP_EN = 1'b1
) (
   input logic             clk,
   input logic             rst,
   sel_onehot_seq_if.slave bus
);

   localparam int unsigned      NOUT   = 1 << SEL_W;
   localparam logic [SEL_W-1:0] IdxMax = '1;

   state_e           state_q;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [NOUT-1:0]  y_q, y_d;
   logic             wrap_q, wrap_d;
   logic             run, tick, adv, at_end;

   // Dropping auto stops the timer on the same edge, so leaving SCAN never advances.
   assign run = (state_q == StScan) && bus.auto;

   sel_onehot_seq_dwell_timer #(
      .DWELL_W(DWELL_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run_i  (run),
      .clr_i  (bus.load | bus.step),
      .dwell_i(bus.dwell),
      .tick_o (tick)
   );

   always_comb begin
      adv    = !bus.load && (bus.step || tick);
      at_end = (bus.dir == DirUp) ? (idx_q == IdxMax) : (idx_q == '0);
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         idx_d = bus.sel;
      end else if (adv) begin
         wrap_d = at_end;
         // Saturating build holds at the limit; arithmetic wraps naturally otherwise.
         if (!at_end || WRAP_EN) begin
            idx_d = (bus.dir == DirUp) ? idx_q + SEL_W'(1) : idx_q - SEL_W'(1);
         end
      end
      y_d = bus.en ? NOUT'(onehot(MaxSelW'(idx_d))) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         y_q     <= '0;
         wrap_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle:  if (bus.auto) state_q <= StScan;
            StScan:  if (!bus.auto) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         idx_q  <= idx_d;
         y_q    <= y_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.y    = y_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;
   assign bus.busy = (state_q == StScan);

endmodule

// File: tb/tb_sel_onehot_seq.sv
// Scoreboard bench: two instances (wrapping and saturating) share one stimulus stream.
// Each vector pushes the expected post-edge status per instance; a negedge monitor pops
// and compares.
module tb_sel_onehot_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       en, load, step, dir, auto;
   logic [2:0] sel;
   logic [7:0] dwell;

   sel_onehot_seq_if #(.SEL_W(3), .DWELL_W(8)) ifw ();
   sel_onehot_seq_if #(.SEL_W(3), .DWELL_W(8)) ifs ();

   assign ifw.en = en;  assign ifw.load = load; assign ifw.sel = sel;  assign ifw.step = step;
   assign ifw.dir = dir; assign ifw.auto = auto; assign ifw.dwell = dwell;
   assign ifs.en = en;  assign ifs.load = load; assign ifs.sel = sel;  assign ifs.step = step;
   assign ifs.dir = dir; assign ifs.auto = auto; assign ifs.dwell = dwell;

   sel_onehot_seq #(.SEL_W(3), .DWELL_W(8), .WRAP_EN(1'b1)) u_wrap (
      .clk(clk), .rst(rst), .bus(ifw)
   );
   sel_onehot_seq #(.SEL_W(3), .DWELL_W(8), .WRAP_EN(1'b0)) u_sat (
      .clk(clk), .rst(rst), .bus(ifs)
   );

   typedef struct {
      logic [7:0] y;
      logic [2:0] idx;
      logic       wrap;
      logic       busy;
      string      name;
   } exp_t;

   exp_t qw[$];
   exp_t qs[$];
   exp_t ew, es;
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (qw.size() > 0) begin
         ew = qw.pop_front();
         check({"wrap.", ew.name, ".y"},    32'(ifw.y),    32'(ew.y));
         check({"wrap.", ew.name, ".idx"},  32'(ifw.idx),  32'(ew.idx));
         check({"wrap.", ew.name, ".wrap"}, 32'(ifw.wrap), 32'(ew.wrap));
         check({"wrap.", ew.name, ".busy"}, 32'(ifw.busy), 32'(ew.busy));
      end
      if (qs.size() > 0) begin
         es = qs.pop_front();
         check({"sat.", es.name, ".y"},    32'(ifs.y),    32'(es.y));
         check({"sat.", es.name, ".idx"},  32'(ifs.idx),  32'(es.idx));
         check({"sat.", es.name, ".wrap"}, 32'(ifs.wrap), 32'(es.wrap));
         check({"sat.", es.name, ".busy"}, 32'(ifs.busy), 32'(es.busy));
      end
   end

   // Apply one cycle of stimulus just after the falling edge.
   task automatic vec(input logic v_en, input logic v_ld, input logic [2:0] v_sel,
                      input logic v_st, input logic v_dir, input logic v_auto,
                      input logic [7:0] v_dw);
      @(negedge clk);
      #1;
      en = v_en; load = v_ld; sel = v_sel; step = v_st; dir = v_dir; auto = v_auto;
      dwell = v_dw;
   endtask

   task automatic pw(input logic [7:0] y, input logic [2:0] idx, input logic wr,
                     input logic bz, input string name);
      exp_t e;
      e.y = y; e.idx = idx; e.wrap = wr; e.busy = bz; e.name = name;
      qw.push_back(e);
   endtask

   task automatic ps(input logic [7:0] y, input logic [2:0] idx, input logic wr,
                     input logic bz, input string name);
      exp_t e;
      e.y = y; e.idx = idx; e.wrap = wr; e.busy = bz; e.name = name;
      qs.push_back(e);
   endtask

   task automatic pb(input logic [7:0] y, input logic [2:0] idx, input logic wr,
                     input logic bz, input string name);
      pw(y, idx, wr, bz, name);
      ps(y, idx, wr, bz, name);
   endtask

   task automatic check_reset(input string name);
      check({"wrap.", name, ".y"},    32'(ifw.y),    32'h0);
      check({"wrap.", name, ".idx"},  32'(ifw.idx),  32'h0);
      check({"wrap.", name, ".wrap"}, 32'(ifw.wrap), 32'h0);
      check({"wrap.", name, ".busy"}, 32'(ifw.busy), 32'h0);
      check({"sat.", name, ".y"},     32'(ifs.y),    32'h0);
      check({"sat.", name, ".idx"},   32'(ifs.idx),  32'h0);
      check({"sat.", name, ".busy"},  32'(ifs.busy), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] ix;
      rst = 1'b1;
      en = 1'b0; load = 1'b0; sel = '0; step = 1'b0; dir = 1'b0; auto = 1'b0; dwell = '0;
      #1;
      check_reset("por");
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Load and output enable.
      vec(1, 1, 3'd6, 0, 0, 0, 8'd0); pb(8'h40, 3'd6, 0, 0, "load6");
      vec(0, 0, 3'd0, 0, 0, 0, 8'd0); pb(8'h00, 3'd6, 0, 0, "en_off");

      // Up/down steps across the ends.
      vec(1, 1, 3'd7, 0, 0, 0, 8'd0); pb(8'h80, 3'd7, 0, 0, "load7");
      vec(1, 0, 3'd0, 1, 0, 0, 8'd0);
      pw(8'h01, 3'd0, 1, 0, "up_end"); ps(8'h80, 3'd7, 1, 0, "up_end");
      vec(1, 0, 3'd0, 0, 0, 0, 8'd0);
      pw(8'h01, 3'd0, 0, 0, "wrap_drop"); ps(8'h80, 3'd7, 0, 0, "wrap_drop");
      vec(1, 0, 3'd0, 1, 1, 0, 8'd0);
      pw(8'h80, 3'd7, 1, 0, "dn_end"); ps(8'h40, 3'd6, 0, 0, "dn_mid");
      vec(1, 1, 3'd0, 0, 0, 0, 8'd0); pb(8'h01, 3'd0, 0, 0, "load0");
      vec(1, 0, 3'd0, 1, 1, 0, 8'd0);
      pw(8'h80, 3'd7, 1, 0, "dn_at0"); ps(8'h01, 3'd0, 1, 0, "dn_at0");
      vec(1, 0, 3'd0, 0, 1, 0, 8'd0);
      pw(8'h80, 3'd7, 0, 0, "hold"); ps(8'h01, 3'd0, 0, 0, "hold");
      vec(1, 0, 3'd0, 1, 0, 0, 8'd0);
      pw(8'h01, 3'd0, 1, 0, "up_from7"); ps(8'h02, 3'd1, 0, 0, "up_from0");
      vec(1, 1, 3'd7, 0, 0, 0, 8'd0); pb(8'h80, 3'd7, 0, 0, "reload7");
      vec(1, 0, 3'd0, 1, 0, 0, 8'd0);
      pw(8'h01, 3'd0, 1, 0, "up_at7"); ps(8'h80, 3'd7, 1, 0, "up_at7");

      // Auto-scan, dwell=3: advance 4 edges after SCAN entry, then every 4 edges.
      vec(1, 1, 3'd2, 0, 0, 0, 8'd0); pb(8'h04, 3'd2, 0, 0, "load2");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd3); pb(8'h04, 3'd2, 0, 1, "scan_enter");
      for (int k = 1; k <= 8; k++) begin
         ix = 3'd2 + 3'(k / 4);
         vec(1, 0, 3'd0, 0, 0, 1, 8'd3);
         pb(8'(1) << ix, ix, 0, 1, "dwell3");
      end

      // dwell=0: every edge; wrapping instance crosses 7->0, saturating one holds at 7.
      vec(1, 0, 3'd0, 0, 0, 1, 8'd0); pb(8'h20, 3'd5, 0, 1, "dw0_5");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd0); pb(8'h40, 3'd6, 0, 1, "dw0_6");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd0); pb(8'h80, 3'd7, 0, 1, "dw0_7");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd0);
      pw(8'h01, 3'd0, 1, 1, "dw0_end"); ps(8'h80, 3'd7, 1, 1, "dw0_end");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd0);
      pw(8'h02, 3'd1, 0, 1, "dw0_post"); ps(8'h80, 3'd7, 1, 1, "dw0_limit");

      // Count up to a due tick, then load+step+tick on the same edge.
      for (int k = 0; k < 3; k++) begin
         vec(1, 0, 3'd0, 0, 0, 1, 8'd3);
         pw(8'h02, 3'd1, 0, 1, "pre_coll"); ps(8'h80, 3'd7, 0, 1, "pre_coll");
      end
      vec(1, 1, 3'd1, 1, 0, 1, 8'd3); pb(8'h02, 3'd1, 0, 1, "collide");
      for (int k = 1; k <= 4; k++) begin
         vec(1, 0, 3'd0, 0, 0, 1, 8'd3);
         if (k < 4) pb(8'h02, 3'd1, 0, 1, "post_coll");
         else       pb(8'h04, 3'd2, 0, 1, "post_coll_adv");
      end

      // Live dwell drop below the running count fires on the next edge.
      for (int k = 0; k < 3; k++) begin
         vec(1, 0, 3'd0, 0, 0, 1, 8'd5); pb(8'h04, 3'd2, 0, 1, "dw5_count");
      end
      vec(1, 0, 3'd0, 0, 0, 1, 8'd1); pb(8'h08, 3'd3, 0, 1, "dw_drop");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd1); pb(8'h08, 3'd3, 0, 1, "dw1_wait");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd1); pb(8'h10, 3'd4, 0, 1, "dw1_adv");

      // Leave SCAN.
      vec(1, 0, 3'd0, 0, 0, 0, 8'd0); pb(8'h10, 3'd4, 0, 0, "scan_exit");
      vec(1, 0, 3'd0, 0, 0, 0, 8'd0); pb(8'h10, 3'd4, 0, 0, "idle");

      // Asynchronous reset mid-scan at idx=5, checked between clock edges.
      vec(1, 1, 3'd5, 0, 0, 0, 8'd0); pb(8'h20, 3'd5, 0, 0, "load5");
      vec(1, 0, 3'd0, 0, 0, 1, 8'd200); pb(8'h20, 3'd5, 0, 1, "scan5");
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset("async_rst");
      vec(1, 0, 3'd0, 0, 0, 0, 8'd0);
      rst = 1'b0;
      pb(8'h01, 3'd0, 0, 0, "post_rst");

      repeat (3) @(negedge clk);
      #1;
      check("drain.wrap_queue", 32'(qw.size()), 32'd0);
      check("drain.sat_queue",  32'(qs.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
